// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
package rr_arb_pkg;

   // Arbiter state: IDLE has no live grant, HOLD presents a registered grant.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Width of a binary index into n sources, never less than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/rr_select_arbiter_pick.sv
// Combinational wrap-around priority picker: first set request at or above
// ptr, wrapping modulo N. Modelled as a scan over a double-width copy of the
// request vector whose lower half is masked below the pointer.
module rr_pick #(
   parameter int N  = 4,
   parameter int AW = 2
)(
   input  logic [N-1:0]  req,
   input  logic [AW-1:0] ptr,
   output logic          found,
   output logic [AW-1:0] idx
);

   int ptr_int;

   // Scan lower (pointer-masked) half first, then the unmasked upper half.
   always_comb begin
      found   = 1'b0;
      idx     = {AW{1'b0}};
      ptr_int = int'(ptr);
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (j >= ptr_int)) begin
            found = 1'b1;
            idx   = AW'(j);
         end else begin
            found = found;
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = AW'(j);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving a word-mux select. The grant is registered and
// held under backpressure; a transfer re-arbitrates in the same cycle with
// the consumed source masked, giving back-to-back transfers.
module rr_select_arbiter
   import rr_arb_pkg::*;
#(
   parameter int INPUT_COUNT = 4,
   parameter int ADDR_WIDTH  = clog2_min1(INPUT_COUNT)
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [INPUT_COUNT-1:0] req_i,
   input  logic                   ready_i,
   output logic                   valid_o,
   output logic [ADDR_WIDTH-1:0]  sel_o,
   output logic [INPUT_COUNT-1:0] grant_o,
   output logic [INPUT_COUNT-1:0] ack_o
);

   state_t                 state;
   state_t                 state_n;
   logic [ADDR_WIDTH-1:0]  ptr;
   logic [ADDR_WIDTH-1:0]  ptr_n;
   logic [ADDR_WIDTH-1:0]  sel_n;
   logic [INPUT_COUNT-1:0] grant_n;
   logic [ADDR_WIDTH-1:0]  next_ptr;
   logic [ADDR_WIDTH-1:0]  pick_ptr;
   logic [INPUT_COUNT-1:0] pick_req;
   logic                   transfer;
   logic                   found;
   logic [ADDR_WIDTH-1:0]  idx;

   assign valid_o  = (state == HOLD);
   assign transfer = valid_o & ready_i;
   assign ack_o    = grant_o & {INPUT_COUNT{transfer}};

   // Candidate set and pointer for this cycle's arbitration; on a transfer the
   // acked source is masked because its req still describes the consumed word.
   always_comb begin
      next_ptr = {ADDR_WIDTH{1'b0}};
      pick_ptr = ptr;
      pick_req = req_i;
      if (sel_o == ADDR_WIDTH'(INPUT_COUNT - 1)) begin
         next_ptr = {ADDR_WIDTH{1'b0}};
      end else begin
         next_ptr = sel_o + ADDR_WIDTH'(1);
      end
      if (transfer) begin
         pick_ptr = next_ptr;
         pick_req = req_i & ~grant_o;
      end else begin
         pick_ptr = ptr;
         pick_req = req_i;
      end
   end

   rr_pick #(
      .N  (INPUT_COUNT),
      .AW (ADDR_WIDTH)
   ) u_pick (
      .req   (pick_req),
      .ptr   (pick_ptr),
      .found (found),
      .idx   (idx)
   );

   // Next-state logic: grant from IDLE, hold or advance in HOLD.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel_o;
      grant_n = grant_o;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = HOLD;
               sel_n   = idx;
               for (int i = 0; i < INPUT_COUNT; i++) begin
                  grant_n[i] = (idx == ADDR_WIDTH'(i));
               end
            end else begin
               state_n = IDLE;
               grant_n = {INPUT_COUNT{1'b0}};
            end
         end
         HOLD: begin
            if (ready_i) begin
               ptr_n = next_ptr;
               if (found) begin
                  state_n = HOLD;
                  sel_n   = idx;
                  for (int i = 0; i < INPUT_COUNT; i++) begin
                     grant_n[i] = (idx == ADDR_WIDTH'(i));
                  end
               end else begin
                  state_n = IDLE;
                  grant_n = {INPUT_COUNT{1'b0}};
               end
            end else begin
               state_n = HOLD;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = {INPUT_COUNT{1'b0}};
         end
      endcase
   end

   // State, pointer and registered grant outputs with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ptr     <= {ADDR_WIDTH{1'b0}};
         sel_o   <= {ADDR_WIDTH{1'b0}};
         grant_o <= {INPUT_COUNT{1'b0}};
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         sel_o   <= sel_n;
         grant_o <= grant_n;
      end
   end

endmodule

// File: doc/rr_select_arbiter.md
Name: rr_select_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's parameterised word multiplexer.
- It chooses one of INPUT_COUNT requesting sources and drives the mux select with the winning index.
- It holds that choice stable under downstream backpressure and returns a per-source acknowledge when the word transfers.
- Output is registered: sel_o and valid_o come from flops, giving a clean timing boundary in front of the combinational mux.

Parameters:
- INPUT_COUNT, 4, number of requesting sources (>=1, need not be a power of two).
- ADDR_WIDTH, max(1,$clog2(INPUT_COUNT)), width of sel_o; must match the mux select width.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  INPUT_COUNT  per-source valid; source holds it high until its ack_o pulse.
- ready_i  input  1  downstream accepts the currently selected word this cycle.
- valid_o  output  1  sel_o/grant_o hold a live grant.
- sel_o  output  ADDR_WIDTH  binary index of granted source; feeds the mux sel_i.
- grant_o  output  INPUT_COUNT  one-hot form of sel_o; all-zero when valid_o=0.
- ack_o  output  INPUT_COUNT  one-hot transfer strobe = grant_o & {INPUT_COUNT{valid_o & ready_i}}; combinational.

Behaviour:
- Reset (rst_i=1 at an edge): valid_o=0, sel_o=0, grant_o=0, priority pointer=0 (source 0 highest). ack_o=0 while valid_o=0. Reset takes effect on the next edge regardless of a held grant; no ack is issued for an aborted grant.
- States: IDLE (valid_o=0) and HOLD (valid_o=1).
- IDLE: if any candidate is requesting, register the winner and go to HOLD. Latency is 1 cycle from req_i to valid_o. Otherwise stay in IDLE.
- Winner selection: the first requesting index scanning upward from the pointer, wrapping modulo INPUT_COUNT (not modulo 2^ADDR_WIDTH).
- HOLD with ready_i=0: sel_o, grant_o and valid_o stay unchanged. req_i changes are ignored, including a protocol-violating drop of the granted req.
- HOLD with ready_i=1 (transfer):
  - ack_o pulses for the granted source.
  - Pointer becomes (sel_o+1) mod INPUT_COUNT.
  - Re-arbitrate in the same cycle over req_i with the just-acked source masked out, because its req_i still describes the consumed word.
  - If another candidate exists: stay in HOLD with the new winner next cycle (back-to-back, 1 transfer/cycle).
  - If none exists: go to IDLE.
- Consequences:
  - A lone requester gets at most 1 transfer per 2 cycles.
  - With all sources requesting, the grant order is strictly rotating.
- Pointer advances only on a transfer, never on a grant alone.
- INPUT_COUNT=1: sel_o is always 0; the source is granted on alternate cycles under continuous ready.
- sel_o never holds a value >= INPUT_COUNT.

Decomposition:
- Package rr_arb_pkg:
  - state enum (IDLE, HOLD);
  - function clog2_min1 for the ADDR_WIDTH default.
- One combinational sub-module rr_pick:
  - inputs: req mask, pointer;
  - outputs: found flag, winner index;
  - implements wrap-around priority by double-width unrolled scan.
- The top level owns the state, pointer and output registers.

Test Plan:
1. INPUT_COUNT=4, rst_i=1 with req_i=4'b1111, ready_i=1 for 3 cycles -> valid_o=0, grant_o=0, ack_o=0, sel_o=0 throughout; first post-reset grant is sel_o=0.
2. Idle, req_i=4'b0100 held, ready_i=1 -> valid_o=1, sel_o=2, ack_o=4'b0100 one cycle later; next cycle valid_o=0; regranted the following cycle (alternating pattern).
3. req_i=4'b1111 held, ready_i=1 -> sel_o sequence 0,1,2,3,0,1 with valid_o=1 every cycle after the first.
4. req_i=4'b0011, ready_i=0 for 3 cycles after grant -> sel_o=0, valid_o=1, ack_o=0 stable; ready_i=1 -> ack_o=4'b0001, next cycle sel_o=1.
5. INPUT_COUNT=3, pointer at 2 after serving source 1, req_i=3'b101 -> sel_o=2, then wraps to sel_o=0; sel_o never equals 3.
6. Grant held on sel_o=3 with ready_i=0, assert rst_i one cycle -> next cycle valid_o=0, no ack_o pulse, pointer=0; with req_i=4'b1001 the next grant is sel_o=0.
